// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the CPU hazard/forwarding controller: miss FSM
// encodings, operand-forward select codes and the stage-enable bundle.
package cpu_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2
    } miss_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Stage-register enables plus the ID/EX bubble request.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic id_ex_flush;
    } stage_ctrl_t;

    // Every stage advances normally.
    function automatic stage_ctrl_t ctrl_run();
        return '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                 ex_mem_write: 1'b1, mem_wb_write: 1'b1, id_ex_flush: 1'b0};
    endfunction

    // Whole pipeline holds its state.
    function automatic stage_ctrl_t ctrl_freeze();
        return '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                 ex_mem_write: 1'b0, mem_wb_write: 1'b0, id_ex_flush: 1'b0};
    endfunction

    // Front end holds, a bubble enters ID/EX, back end keeps draining.
    function automatic stage_ctrl_t ctrl_bubble();
        return '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                 ex_mem_write: 1'b1, mem_wb_write: 1'b1, id_ex_flush: 1'b1};
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Bundle of pipeline status inputs and control outputs exchanged between the
// datapath (master) and the hazard/forwarding controller (slave).
interface hazard_forward_ctrl_if
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic                  ID_UsesRt;
    logic [REG_ADDR_W-1:0] EX_Rs;
    logic [REG_ADDR_W-1:0] EX_Rt;
    logic [REG_ADDR_W-1:0] EX_Rd;
    logic                  EX_RegWrite;
    logic                  EX_MemRead;
    logic [REG_ADDR_W-1:0] MEM_Rd;
    logic                  MEM_RegWrite;
    logic                  MEM_MemAccess;
    logic [REG_ADDR_W-1:0] WB_Rd;
    logic                  WB_RegWrite;
    logic                  icache_ready;
    logic                  dcache_ready;

    logic [1:0]            ForwardA;
    logic [1:0]            ForwardB;
    logic                  PC_Write;
    logic                  IF_ID_Write;
    logic                  ID_EX_Write;
    logic                  EX_MEM_Write;
    logic                  MEM_WB_Write;
    logic                  ID_EX_Flush;
    logic [1:0]            miss_state;
    logic [CNT_W-1:0]      dmiss_cycles;
    logic                  miss_timeout;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_Rs, EX_Rt, EX_Rd, EX_RegWrite,
               EX_MemRead, MEM_Rd, MEM_RegWrite, MEM_MemAccess, WB_Rd,
               WB_RegWrite, icache_ready, dcache_ready,
        input  ForwardA, ForwardB, PC_Write, IF_ID_Write, ID_EX_Write,
               EX_MEM_Write, MEM_WB_Write, ID_EX_Flush, miss_state,
               dmiss_cycles, miss_timeout
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_Rs, EX_Rt, EX_Rd, EX_RegWrite,
               EX_MemRead, MEM_Rd, MEM_RegWrite, MEM_MemAccess, WB_Rd,
               WB_RegWrite, icache_ready, dcache_ready,
        output ForwardA, ForwardB, PC_Write, IF_ID_Write, ID_EX_Write,
               EX_MEM_Write, MEM_WB_Write, ID_EX_Flush, miss_state,
               dmiss_cycles, miss_timeout
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Operand forward select for one EX source register. The youngest producer
// (MEM) wins over WB; register 0 is never forwarded.
module fwd_select
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            sel
);

    // Priority compare: MEM result first, then WB, else register file.
    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Central hazard controller: EX operand forwarding, load-use bubble insertion
// and the I/D-cache miss freeze FSM, plus a D-miss stall counter and a sticky
// timeout flag for stuck D-cache accesses.
module hazard_forward_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);

    // Timeout counter just wide enough to hold MISS_TIMEOUT.
    localparam int                TO_W        = $clog2(MISS_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LIMIT    = TO_W'(MISS_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LIMIT_M1 = TO_W'(MISS_TIMEOUT - 1);

    miss_state_t      state;
    miss_state_t      state_nxt;
    stage_ctrl_t      ctrl;
    logic             lu;
    logic             dmiss_start;
    logic             dmiss_stall;
    logic [CNT_W-1:0] dmiss_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout_flag;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src           (bus.EX_Rs),
        .mem_rd        (bus.MEM_Rd),
        .mem_reg_write (bus.MEM_RegWrite),
        .wb_rd         (bus.WB_Rd),
        .wb_reg_write  (bus.WB_RegWrite),
        .sel           (fwd_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src           (bus.EX_Rt),
        .mem_rd        (bus.MEM_Rd),
        .mem_reg_write (bus.MEM_RegWrite),
        .wb_rd         (bus.WB_Rd),
        .wb_reg_write  (bus.WB_RegWrite),
        .sel           (fwd_b)
    );

    // Load in EX whose result the ID instruction needs next cycle.
    always_comb begin
        lu = 1'b0;
        if (bus.EX_MemRead && bus.EX_RegWrite && (bus.EX_Rd != '0)) begin
            lu = (bus.EX_Rd == bus.ID_Rs) ||
                 (bus.ID_UsesRt && (bus.EX_Rd == bus.ID_Rt));
        end
    end

    // A stall cycle is counted both on D-miss detection and while waiting.
    assign dmiss_start = bus.MEM_MemAccess && !bus.dcache_ready;
    assign dmiss_stall = (state == DMISS) ? !bus.dcache_ready : dmiss_start;

    // Miss FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stage enables; a D-miss always wins over an I-miss.
    always_comb begin
        state_nxt = state;
        ctrl      = ctrl_run();
        unique case (state)
            RUN: begin
                if (dmiss_start) begin
                    ctrl      = ctrl_freeze();
                    state_nxt = DMISS;
                end else if (!bus.icache_ready) begin
                    ctrl      = ctrl_bubble();
                    state_nxt = IMISS;
                end else if (lu) begin
                    ctrl      = ctrl_bubble();
                end
            end
            IMISS: begin
                if (dmiss_start) begin
                    ctrl      = ctrl_freeze();
                    state_nxt = DMISS;
                end else if (!bus.icache_ready) begin
                    ctrl      = ctrl_bubble();
                end else begin
                    state_nxt = RUN;
                    if (lu) begin
                        ctrl = ctrl_bubble();
                    end
                end
            end
            DMISS: begin
                if (!bus.dcache_ready) begin
                    ctrl      = ctrl_freeze();
                end else if (!bus.icache_ready) begin
                    ctrl      = ctrl_bubble();
                    state_nxt = IMISS;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // D-miss stall counter, per-miss timeout counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmiss_cnt    <= '0;
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if (dmiss_stall) begin
            dmiss_cnt <= sat_inc(dmiss_cnt);
            if (to_cnt != TO_LIMIT) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt == TO_LIMIT_M1) begin
                timeout_flag <= 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    assign bus.ForwardA     = fwd_a;
    assign bus.ForwardB     = fwd_b;
    assign bus.PC_Write     = ctrl.pc_write;
    assign bus.IF_ID_Write  = ctrl.if_id_write;
    assign bus.ID_EX_Write  = ctrl.id_ex_write;
    assign bus.EX_MEM_Write = ctrl.ex_mem_write;
    assign bus.MEM_WB_Write = ctrl.mem_wb_write;
    assign bus.ID_EX_Flush  = ctrl.id_ex_flush;
    assign bus.miss_state   = state;
    assign bus.dmiss_cycles = dmiss_cnt;
    assign bus.miss_timeout = timeout_flag;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: table of single-cycle forwarding/load-use
// vectors followed by hand-written cache-miss sequences, checked through a
// scoreboard queue at the falling edge.
module tb_hazard_forward_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int RW = 5;
    localparam int CW = 3;
    localparam int MT = 4;

    // {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write, ID_EX_Flush}
    localparam logic [5:0] EN_ALL = 6'b111110;
    localparam logic [5:0] EN_FRZ = 6'b000000;
    localparam logic [5:0] EN_BUB = 6'b001111;

    typedef struct {
        logic [8*12-1:0] name;
        logic [RW-1:0]   id_rs, id_rt;
        logic            id_uses_rt;
        logic [RW-1:0]   ex_rs, ex_rt, ex_rd;
        logic            ex_rw, ex_mr;
        logic [RW-1:0]   mem_rd;
        logic            mem_rw, mem_acc;
        logic [RW-1:0]   wb_rd;
        logic            wb_rw, ic, dc, rs, chk;
        logic [1:0]      fa, fb;
        logic [5:0]      en;
        logic [1:0]      st;
        logic [CW-1:0]   cnt;
        logic            to;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [CW-1:0] exp_cnt;
    logic          exp_to;
    vec_t sb[$];
    vec_t e;
    logic [15:0] got, want;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    hazard_forward_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MISS_TIMEOUT(MT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic [8*12-1:0] nm);
        vec_t v;
        v.name = nm;
        v.id_rs = '0; v.id_rt = '0; v.id_uses_rt = 1'b0;
        v.ex_rs = '0; v.ex_rt = '0; v.ex_rd = '0; v.ex_rw = 1'b0; v.ex_mr = 1'b0;
        v.mem_rd = '0; v.mem_rw = 1'b0; v.mem_acc = 1'b0;
        v.wb_rd = '0; v.wb_rw = 1'b0;
        v.ic = 1'b1; v.dc = 1'b1; v.rs = 1'b0; v.chk = 1'b1;
        v.fa = FWD_RF; v.fb = FWD_RF; v.en = EN_ALL; v.st = 2'd0;
        v.cnt = exp_cnt; v.to = exp_to;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.ID_Rs = v.id_rs; bus.ID_Rt = v.id_rt; bus.ID_UsesRt = v.id_uses_rt;
        bus.EX_Rs = v.ex_rs; bus.EX_Rt = v.ex_rt; bus.EX_Rd = v.ex_rd;
        bus.EX_RegWrite = v.ex_rw; bus.EX_MemRead = v.ex_mr;
        bus.MEM_Rd = v.mem_rd; bus.MEM_RegWrite = v.mem_rw; bus.MEM_MemAccess = v.mem_acc;
        bus.WB_Rd = v.wb_rd; bus.WB_RegWrite = v.wb_rw;
        bus.icache_ready = v.ic; bus.dcache_ready = v.dc;
        rst = v.rs;
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(v);
    endtask

    // Scoreboard checker: one expected record per cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                total++;
                got  = {bus.ForwardA, bus.ForwardB, bus.PC_Write, bus.IF_ID_Write,
                        bus.ID_EX_Write, bus.EX_MEM_Write, bus.MEM_WB_Write,
                        bus.ID_EX_Flush, bus.miss_state, bus.dmiss_cycles, bus.miss_timeout};
                want = {e.fa, e.fb, e.en, e.st, e.cnt, e.to};
                if (got !== want) begin
                    bad++;
                    $display("FAIL %s got fa_fb_en_st_cnt_to=%b want=%b", e.name, got, want);
                end
            end
        end
    end

    vec_t tbl[11];
    vec_t v;

    initial begin
        exp_cnt = '0;
        exp_to  = 1'b0;
        v = mk("idle");
        v.rs = 1'b1;
        drive(v);

        // Reset state
        v = mk("rst0"); v.rs = 1'b1; v.chk = 1'b0; step(v);
        v = mk("rst1"); v.rs = 1'b1; step(v);

        // Single-cycle forwarding and load-use vectors, all in RUN
        tbl[0] = mk("fwdA_mem"); tbl[0].ex_rs = 3; tbl[0].mem_rd = 3; tbl[0].mem_rw = 1;
        tbl[0].wb_rd = 3; tbl[0].wb_rw = 1; tbl[0].fa = FWD_MEM;
        tbl[1] = tbl[0]; tbl[1].name = "fwdA_wb"; tbl[1].mem_rd = 0; tbl[1].fa = FWD_WB;
        tbl[2] = mk("fwdB_wb"); tbl[2].ex_rt = 4; tbl[2].mem_rd = 4; tbl[2].mem_rw = 0;
        tbl[2].wb_rd = 4; tbl[2].wb_rw = 1; tbl[2].fb = FWD_WB;
        tbl[3] = mk("fwdAB_mem"); tbl[3].ex_rs = 7; tbl[3].ex_rt = 7; tbl[3].mem_rd = 7;
        tbl[3].mem_rw = 1; tbl[3].fa = FWD_MEM; tbl[3].fb = FWD_MEM;
        tbl[4] = mk("fwd_r0"); tbl[4].mem_rw = 1; tbl[4].wb_rw = 1;
        tbl[5] = mk("lu_rt"); tbl[5].ex_mr = 1; tbl[5].ex_rw = 1; tbl[5].ex_rd = 5;
        tbl[5].id_rt = 5; tbl[5].id_uses_rt = 1; tbl[5].en = EN_BUB;
        tbl[6] = mk("lu_next"); tbl[6].mem_rd = 5; tbl[6].mem_rw = 1; tbl[6].mem_acc = 1;
        tbl[6].ex_rt = 5; tbl[6].fb = FWD_MEM;
        tbl[7] = mk("lu_rd0"); tbl[7].ex_mr = 1; tbl[7].ex_rw = 1; tbl[7].id_uses_rt = 1;
        tbl[8] = mk("lu_nouse"); tbl[8].ex_mr = 1; tbl[8].ex_rw = 1; tbl[8].ex_rd = 5;
        tbl[8].id_rt = 5;
        tbl[9] = mk("lu_rs"); tbl[9].ex_mr = 1; tbl[9].ex_rw = 1; tbl[9].ex_rd = 5;
        tbl[9].id_rs = 5; tbl[9].en = EN_BUB;
        tbl[10] = tbl[9]; tbl[10].name = "lu_norw"; tbl[10].ex_rw = 0; tbl[10].en = EN_ALL;
        for (int i = 0; i < 11; i++) step(tbl[i]);

        // I-miss for 3 cycles while a load drains, then ready with a load-use
        v = mk("im1"); v.ic = 0; v.ex_rs = 5; v.mem_rd = 5; v.mem_rw = 1; v.mem_acc = 1;
        v.fa = FWD_MEM; v.en = EN_BUB; step(v);
        v = mk("im2"); v.ic = 0; v.ex_rs = 5; v.wb_rd = 5; v.wb_rw = 1;
        v.fa = FWD_WB; v.en = EN_BUB; v.st = 2'd1; step(v);
        v = mk("im3"); v.ic = 0; v.en = EN_BUB; v.st = 2'd1; step(v);
        v = mk("im4_lu"); v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 6; v.id_rs = 6;
        v.en = EN_BUB; v.st = 2'd1; step(v);
        v = mk("im5"); step(v);

        // D-miss starting during an I-miss, released with I-miss still pending
        v = mk("id1"); v.ic = 0; v.en = EN_BUB; step(v);
        v = mk("id2"); v.ic = 0; v.mem_acc = 1; v.dc = 0; v.en = EN_FRZ; v.st = 2'd1; step(v);
        exp_cnt = 1;
        v = mk("id3"); v.ic = 0; v.mem_acc = 1; v.dc = 0; v.en = EN_FRZ; v.st = 2'd2; step(v);
        exp_cnt = 2;
        v = mk("id4"); v.ic = 0; v.mem_acc = 1; v.en = EN_BUB; v.st = 2'd2; step(v);
        v = mk("id5"); v.st = 2'd1; step(v);
        v = mk("id6"); step(v);

        // Reset in the middle of a D-miss
        v = mk("rm1"); v.mem_acc = 1; v.dc = 0; v.en = EN_FRZ; step(v);
        exp_cnt = 3;
        v = mk("rm2"); v.mem_acc = 1; v.dc = 0; v.en = EN_FRZ; v.st = 2'd2; step(v);
        exp_cnt = 4;
        v = mk("rm3"); v.mem_acc = 1; v.dc = 0; v.en = EN_FRZ; v.st = 2'd2; step(v);
        v = mk("rm4"); v.mem_acc = 1; v.dc = 0; v.rs = 1; v.chk = 0; step(v);
        exp_cnt = 0;
        v = mk("rm5"); step(v);

        // Store misses for 7 cycles; timeout flag rises after the 4th
        for (int k = 1; k <= 7; k++) begin
            exp_cnt = CW'(k - 1);
            exp_to  = (k >= 5);
            v = mk("dm_wait"); v.mem_acc = 1; v.dc = 0; v.en = EN_FRZ;
            v.st = (k == 1) ? 2'd0 : 2'd2;
            step(v);
        end
        exp_cnt = 7;
        v = mk("dm_rel"); v.mem_acc = 1; v.st = 2'd2; step(v);
        v = mk("dm_after"); step(v);

        // Counter saturation; D-miss beats a simultaneous I-miss from RUN
        v = mk("sat1"); v.mem_acc = 1; v.dc = 0; v.ic = 0; v.en = EN_FRZ; step(v);
        v = mk("sat2"); v.mem_acc = 1; v.dc = 0; v.ic = 0; v.en = EN_FRZ; v.st = 2'd2; step(v);
        v = mk("sat3"); v.mem_acc = 1; v.st = 2'd2; step(v);
        v = mk("sat4"); step(v);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
